// File: rtl/dfr_pkg.sv
// Shared types and defaults for the DFR output layer: FSM encoding and bus widths.
package dfr_pkg;

  localparam int unsigned DfrDataWidth = 32;
  localparam int unsigned DfrAddrWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StLoad,
    StIssue,
    StWaitHi,
    StWaitLo,
    StFinish
  } dfr_state_e;

endpackage

// File: rtl/dfr_output_sequencer.sv
// Walks N (state, weight) pairs out of two sync-read RAMs into an external MAC and latches
// the accumulated dot product.
module dfr_output_sequencer
  import dfr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DfrDataWidth,
  parameter int unsigned ADDR_WIDTH = DfrAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_elems,
  output logic [ADDR_WIDTH-1:0] state_addr,
  input  logic [DATA_WIDTH-1:0] state_data,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  input  logic [DATA_WIDTH-1:0] weight_data,
  output logic                  mac_rst,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_start,
  input  logic                  mac_busy,
  input  logic [DATA_WIDTH-1:0] mac_dout,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done
);

  dfr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  assign idx_inc = idx_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      idx_q    <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
      result_q <= result_d;
    end
  end

  // Result is captured on entry to StFinish so it is already valid while done is high.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    mac_a_d  = mac_a_q;
    mac_b_d  = mac_b_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = num_elems;
          idx_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (len_q == '0) begin
          // The MAC is being cleared this very cycle, so its output is not yet zero.
          result_d = '0;
          state_d  = StFinish;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        mac_a_d = state_data;
        mac_b_d = weight_data;
        state_d = StIssue;
      end
      StIssue: state_d = StWaitHi;
      StWaitHi: begin
        if (mac_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!mac_busy) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            result_d = mac_dout;
            state_d  = StFinish;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StFinish);
    mac_rst     = (state_q == StClear);
    mac_start   = (state_q == StIssue);
    state_addr  = idx_q;
    weight_addr = idx_q;
    mac_a       = mac_a_q;
    mac_b       = mac_b_q;
    result      = result_q;
  end

endmodule
